// File: rtl/simt_pkg.sv
// Shared SIMT core types: atomic opcode encoding and the LSU atomic instruction class.
package simt_pkg;

    localparam int unsigned SIMT_NUM_LANES = 32;
    localparam int unsigned SIMT_ADDR_W    = 32;
    localparam int unsigned SIMT_DATA_W    = 32;
    localparam int unsigned SIMT_WID_W     = 5;

    typedef enum logic [1:0] {
        ATOM_OR,
        ATOM_AND,
        ATOM_ADD,
        ATOM_XCHG
    } atom_op_e;

    localparam logic [5:0] OP_ATOM = 6'h2C;

endpackage

// File: rtl/atomic_lane_merge.sv
// Picks the lowest pending lane as leader, gathers every pending lane hitting the same
// word, and folds their operands into one combined operand for the chosen opcode.
module atomic_lane_merge
    import simt_pkg::*;
#(
    parameter int unsigned NUM_LANES = SIMT_NUM_LANES,
    parameter int unsigned ADDR_W    = SIMT_ADDR_W,
    parameter int unsigned DATA_W    = SIMT_DATA_W
) (
    input  logic [NUM_LANES-1:0]        pending,
    input  logic [NUM_LANES*ADDR_W-1:0] addr,
    input  logic [NUM_LANES*DATA_W-1:0] data,
    input  atom_op_e                    op,
    output logic [ADDR_W-1:0]           leader_addr,
    output logic [NUM_LANES-1:0]        match_mask,
    output logic [DATA_W-1:0]           combined
);

    localparam int unsigned WORD_W = ADDR_W - 2;

    logic              w_found;
    logic [WORD_W-1:0] w_leader_word;
    logic [NUM_LANES-1:0] w_unused_addr_lsbs;

    // Leader is the lowest-index pending lane.
    always_comb begin
        w_found       = 1'b0;
        w_leader_word = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (pending[i] && !w_found) begin
                w_found       = 1'b1;
                w_leader_word = addr[i*ADDR_W+2 +: WORD_W];
            end
        end
    end

    always_comb begin
        match_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            match_mask[i] = pending[i] && (addr[i*ADDR_W+2 +: WORD_W] == w_leader_word);
        end
    end

    // XCHG keeps the highest-index matched operand since later lanes overwrite earlier ones.
    always_comb begin
        combined = (op == ATOM_AND) ? '1 : '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (match_mask[i]) begin
                case (op)
                    ATOM_OR:   combined = combined | data[i*DATA_W +: DATA_W];
                    ATOM_AND:  combined = combined & data[i*DATA_W +: DATA_W];
                    ATOM_ADD:  combined = combined + data[i*DATA_W +: DATA_W];
                    default:   combined = data[i*DATA_W +: DATA_W];
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            w_unused_addr_lsbs[i] = ^addr[i*ADDR_W +: 2];
        end
    end

    assign leader_addr = {w_leader_word, 2'b00};

endmodule

// File: rtl/atomic_rmw_sequencer.sv
// Serializes a warp-wide atomic into one read/modify/write per unique word, returning
// each lane's pre-update value; a single memory transaction is outstanding at a time.
module atomic_rmw_sequencer
    import simt_pkg::*;
#(
    parameter int unsigned NUM_LANES = SIMT_NUM_LANES,
    parameter int unsigned ADDR_W    = SIMT_ADDR_W,
    parameter int unsigned DATA_W    = SIMT_DATA_W,
    parameter int unsigned WID_W     = SIMT_WID_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [1:0]                  req_op,
    input  logic [WID_W-1:0]            req_warp,
    input  logic [NUM_LANES-1:0]        req_mask,
    input  logic [NUM_LANES*ADDR_W-1:0] req_addr,
    input  logic [NUM_LANES*DATA_W-1:0] req_data,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic                        mem_req_we,
    output logic [ADDR_W-1:0]           mem_req_addr,
    output logic [DATA_W-1:0]           mem_req_wdata,
    input  logic                        mem_resp_valid,
    input  logic [DATA_W-1:0]           mem_resp_rdata,
    output logic                        done_valid,
    output logic [WID_W-1:0]            done_warp,
    output logic [NUM_LANES*DATA_W-1:0] done_old
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_DONE
    } state_e;

    state_e                      r_state;
    state_e                      w_next;
    atom_op_e                    r_op;
    logic [NUM_LANES*ADDR_W-1:0] r_addr;
    logic [NUM_LANES*DATA_W-1:0] r_data;
    logic [NUM_LANES-1:0]        r_pending;
    logic [NUM_LANES-1:0]        r_match;
    logic [DATA_W-1:0]           r_comb;

    logic                        r_req_ready;
    logic                        r_mem_req_valid;
    logic                        r_mem_req_we;
    logic [ADDR_W-1:0]           r_mem_req_addr;
    logic [DATA_W-1:0]           r_mem_req_wdata;
    logic                        r_done_valid;
    logic [WID_W-1:0]            r_done_warp;
    logic [NUM_LANES*DATA_W-1:0] r_done_old;

    logic [ADDR_W-1:0]           w_leader_addr;
    logic [NUM_LANES-1:0]        w_match_mask;
    logic [DATA_W-1:0]           w_combined;
    logic [DATA_W-1:0]           w_new;
    logic                        w_accept;
    logic                        w_pick;
    logic                        w_rd_resp;
    logic                        w_wr_done;

    atomic_lane_merge #(
        .NUM_LANES (NUM_LANES),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) u_merge (
        .pending     (r_pending),
        .addr        (r_addr),
        .data        (r_data),
        .op          (r_op),
        .leader_addr (w_leader_addr),
        .match_mask  (w_match_mask),
        .combined    (w_combined)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (req_valid) w_next = (req_mask == '0) ? S_DONE : S_PICK;
            S_PICK:    w_next = S_RD_REQ;
            S_RD_REQ:  if (mem_req_ready) w_next = S_RD_WAIT;
            S_RD_WAIT: if (mem_resp_valid) w_next = S_WR_REQ;
            S_WR_REQ:  if (mem_req_ready)
                           w_next = ((r_pending & ~r_match) == '0) ? S_DONE : S_PICK;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Datapath strobes and the RMW result for the word currently in flight.
    always_comb begin
        w_accept  = (r_state == S_IDLE) && req_valid;
        w_pick    = (r_state == S_PICK);
        w_rd_resp = (r_state == S_RD_WAIT) && mem_resp_valid;
        w_wr_done = (r_state == S_WR_REQ) && mem_req_ready;
        case (r_op)
            ATOM_OR:  w_new = mem_resp_rdata | r_comb;
            ATOM_AND: w_new = mem_resp_rdata & r_comb;
            ATOM_ADD: w_new = mem_resp_rdata + r_comb;
            default:  w_new = r_comb;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op            <= ATOM_OR;
            r_addr          <= '0;
            r_data          <= '0;
            r_pending       <= '0;
            r_match         <= '0;
            r_comb          <= '0;
            r_req_ready     <= 1'b1;
            r_mem_req_valid <= 1'b0;
            r_mem_req_we    <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_req_wdata <= '0;
            r_done_valid    <= 1'b0;
            r_done_warp     <= '0;
            r_done_old      <= '0;
        end else begin
            r_req_ready     <= (w_next == S_IDLE);
            r_mem_req_valid <= (w_next == S_RD_REQ) || (w_next == S_WR_REQ);
            r_mem_req_we    <= (w_next == S_WR_REQ);
            r_done_valid    <= (w_next == S_DONE);
            if (w_accept) begin
                r_op        <= atom_op_e'(req_op);
                r_addr      <= req_addr;
                r_data      <= req_data;
                r_pending   <= req_mask;
                r_done_warp <= req_warp;
                r_done_old  <= '0;
            end
            if (w_pick) begin
                r_match        <= w_match_mask;
                r_comb         <= w_combined;
                r_mem_req_addr <= w_leader_addr;
            end
            if (w_rd_resp) begin
                r_mem_req_wdata <= w_new;
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (r_match[i]) r_done_old[i*DATA_W +: DATA_W] <= mem_resp_rdata;
                end
            end
            if (w_wr_done) r_pending <= r_pending & ~r_match;
        end
    end

    assign req_ready     = r_req_ready;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_we    = r_mem_req_we;
    assign mem_req_addr  = r_mem_req_addr;
    assign mem_req_wdata = r_mem_req_wdata;
    assign done_valid    = r_done_valid;
    assign done_warp     = r_done_warp;
    assign done_old      = r_done_old;

endmodule
